// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared widths, load/store opcodes, LSU state encodings and opcode decode helpers
package mem_lsu_pkg;
    localparam int RegBus = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus = 8;
    localparam logic [AluOpBus-1:0] EXE_ADD_OP = 8'h20;
    localparam logic [AluOpBus-1:0] EXE_LB_OP = 8'h40;
    localparam logic [AluOpBus-1:0] EXE_LH_OP = 8'h41;
    localparam logic [AluOpBus-1:0] EXE_LW_OP = 8'h42;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'h44;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'h45;
    localparam logic [AluOpBus-1:0] EXE_SB_OP = 8'h48;
    localparam logic [AluOpBus-1:0] EXE_SH_OP = 8'h49;
    localparam logic [AluOpBus-1:0] EXE_SW_OP = 8'h4a;
    localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;
    localparam logic [0:0] LSU_IDLE = 1'b0;
    localparam logic [0:0] LSU_BUS = 1'b1;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_NONE} size_e;

    function automatic size_e op_size(input logic [AluOpBus-1:0] op);
        return (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) ? SZ_B :
               (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) ? SZ_H :
               (op inside {EXE_LW_OP, EXE_SW_OP}) ? SZ_W : SZ_NONE;
    endfunction

    function automatic logic is_store(input logic [AluOpBus-1:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic is_signed_load(input logic [AluOpBus-1:0] op);
        return op inside {EXE_LB_OP, EXE_LH_OP};
    endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: data-bus request/acknowledge channel between the LSU and the data memory
interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] rdata;
    modport master(output req, we, addr, wdata, sel, input ack, rdata);
    modport slave(input req, we, addr, wdata, sel, output ack, rdata);
endinterface

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: byte-lane select, store replication, misalign detect and load extension
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [AluOpBus-1:0] op,
    input  logic [1:0]          off,
    input  logic [31:0]         sdata,
    output logic [3:0]          sel,
    output logic [31:0]         wdata,
    output logic                misalign,
    input  logic [AluOpBus-1:0] ld_op,
    input  logic [1:0]          ld_off,
    input  logic [31:0]         rdata,
    output logic [31:0]         ldata
);
    size_e       sz;
    size_e       ld_sz;
    logic [31:0] sh;
    logic        sx;

    always_comb begin
        sz = op_size(op);
        sel = sz == SZ_B ? 4'b0001 << off : sz == SZ_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata = sz == SZ_B ? {4{sdata[7:0]}} : sz == SZ_H ? {2{sdata[15:0]}} : sdata;
        misalign = (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
        ld_sz = op_size(ld_op);
        sx = is_signed_load(ld_op);
        sh = rdata >> {ld_off, 3'b000};
        ldata = ld_sz == SZ_B ? {{24{sx & sh[7]}}, sh[7:0]} :
                ld_sz == SZ_H ? {{16{sx & sh[15]}}, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage; passes ALU results through and runs load/store bus transactions
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [RegAddrBus-1:0] reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [RegBus-1:0]     reg_wdata_i,
    input  logic [RegBus-1:0]     store_data_i,
    output logic                  stallreq_o,
    output logic                  valid_o,
    output logic [RegAddrBus-1:0] reg_waddr_o,
    output logic                  reg_we_o,
    output logic [RegBus-1:0]     reg_wdata_o,
    output logic                  misalign_o,
    mem_lsu_if.master             bus
);
    logic [0:0]          state;
    logic [AluOpBus-1:0] op_q;
    logic [1:0]          off_q;
    logic                we_q;
    logic                mem_op;
    logic                misalign;
    logic                go;
    logic [3:0]          sel;
    logic [31:0]         wdata;
    logic [31:0]         ldata;

    mem_lsu_align u_align (
        .op       (aluop_i),
        .off      (reg_wdata_i[1:0]),
        .sdata    (store_data_i),
        .sel      (sel),
        .wdata    (wdata),
        .misalign (misalign),
        .ld_op    (op_q),
        .ld_off   (off_q),
        .rdata    (bus.rdata),
        .ldata    (ldata)
    );

    assign mem_op = op_size(aluop_i) != SZ_NONE;
    assign go = valid_i && mem_op && !misalign;
    assign stallreq_o = (state == LSU_IDLE && go) || (state == LSU_BUS && !bus.ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LSU_IDLE;
            op_q <= '0;
            off_q <= '0;
            we_q <= 1'b0;
            valid_o <= 1'b0;
            reg_waddr_o <= '0;
            reg_we_o <= 1'b0;
            reg_wdata_o <= '0;
            misalign_o <= 1'b0;
            bus.req <= 1'b0;
            bus.we <= 1'b0;
            bus.addr <= '0;
            bus.wdata <= '0;
            bus.sel <= '0;
        end else if (state == LSU_IDLE) begin
            valid_o <= valid_i && !go;
            misalign_o <= valid_i && mem_op && misalign;
            if (valid_i) begin
                reg_waddr_o <= reg_waddr_i;
                reg_we_o <= reg_we_i && !mem_op;
                reg_wdata_o <= reg_wdata_i;
            end
            if (go) begin
                op_q <= aluop_i;
                off_q <= reg_wdata_i[1:0];
                we_q <= reg_we_i;
                bus.req <= 1'b1;
                bus.we <= is_store(aluop_i);
                bus.addr <= {reg_wdata_i[31:2], 2'b00};
                bus.wdata <= wdata;
                bus.sel <= sel;
                state <= LSU_BUS;
            end
        end else if (bus.ack) begin
            // request fields other than req are left as-is; only req qualifies them
            bus.req <= 1'b0;
            state <= LSU_IDLE;
            valid_o <= 1'b1;
            reg_we_o <= we_q && !is_store(op_q);
            reg_wdata_o <= is_store(op_q) ? reg_wdata_o : ldata;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vectors with hand-computed results for the memory-access stage
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [7:0]  aluop_i = 8'h0;
    logic [4:0]  reg_waddr_i = 5'd0;
    logic        reg_we_i = 1'b0;
    logic [31:0] reg_wdata_i = 32'h0;
    logic [31:0] store_data_i = 32'h0;
    logic        stallreq_o;
    logic        valid_o;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        misalign_o;
    int          n_chk = 0;
    int          n_err = 0;

    mem_lsu_if bus_if();

    mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .aluop_i      (aluop_i),
        .reg_waddr_i  (reg_waddr_i),
        .reg_we_i     (reg_we_i),
        .reg_wdata_i  (reg_wdata_i),
        .store_data_i (store_data_i),
        .stallreq_o   (stallreq_o),
        .valid_o      (valid_o),
        .reg_waddr_o  (reg_waddr_o),
        .reg_we_o     (reg_we_o),
        .reg_wdata_o  (reg_wdata_o),
        .misalign_o   (misalign_o),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] sd);
        valid_i = 1'b1;
        aluop_i = op;
        reg_waddr_i = rd;
        reg_we_i = 1'b1;
        reg_wdata_i = a;
        store_data_i = sd;
        #1;
    endtask

    task automatic mem_tx(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int k, input logic [3:0] esel, input logic [31:0] ebw,
                          input logic st, input logic [31:0] ewb);
        issue(op, 5'd7, a, sd);
        chk({tag, "_stall_c0"}, 32'(stallreq_o), 32'd1);
        for (int c = 1; c <= k; c++) begin
            step();
            valid_i = 1'b0;
            aluop_i = EXE_ADD_OP;
            bus_if.ack = (c == k);
            bus_if.rdata = (c == k) ? rd : 32'h0;
            #1;
            chk({tag, "_req"}, 32'(bus_if.req), 32'd1);
            chk({tag, "_addr"}, bus_if.addr, {a[31:2], 2'b00});
            chk({tag, "_sel"}, 32'(bus_if.sel), 32'(esel));
            chk({tag, "_bwe"}, 32'(bus_if.we), 32'(st));
            if (st) chk({tag, "_bwdata"}, bus_if.wdata, ebw);
            chk({tag, "_stall"}, 32'(stallreq_o), 32'(c != k));
            chk({tag, "_valid_busy"}, 32'(valid_o), 32'd0);
        end
        step();
        bus_if.ack = 1'b0;
        #1;
        chk({tag, "_wb_valid"}, 32'(valid_o), 32'd1);
        chk({tag, "_wb_we"}, 32'(reg_we_o), 32'(!st));
        chk({tag, "_wb_waddr"}, 32'(reg_waddr_o), 32'd7);
        chk({tag, "_req_done"}, 32'(bus_if.req), 32'd0);
        if (!st) chk({tag, "_wb_data"}, reg_wdata_o, ewb);
        step();
    endtask

    task automatic mis_tx(input string tag, input logic [7:0] op, input logic [31:0] a);
        issue(op, 5'd4, a, 32'h0);
        chk({tag, "_stall"}, 32'(stallreq_o), 32'd0);
        step();
        valid_i = 1'b0;
        #1;
        chk({tag, "_pulse"}, 32'(misalign_o), 32'd1);
        chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        chk({tag, "_we"}, 32'(reg_we_o), 32'd0);
        chk({tag, "_req"}, 32'(bus_if.req), 32'd0);
        step();
        chk({tag, "_pulse_end"}, 32'(misalign_o), 32'd0);
        chk({tag, "_req_after"}, 32'(bus_if.req), 32'd0);
    endtask

    initial begin
        bus_if.ack = 1'b0;
        bus_if.rdata = 32'h0;
        #3;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_req", 32'(bus_if.req), 32'd0);
        chk("rst_sel", 32'(bus_if.sel), 32'd0);
        chk("rst_wdata", reg_wdata_o, 32'd0);
        step();
        rst = 1'b0;
        step();
        issue(EXE_ADD_OP, 5'd3, 32'h5, 32'h0);
        chk("add_stall", 32'(stallreq_o), 32'd0);
        step();
        valid_i = 1'b0;
        #1;
        chk("add_valid", 32'(valid_o), 32'd1);
        chk("add_waddr", 32'(reg_waddr_o), 32'd3);
        chk("add_wdata", reg_wdata_o, 32'h5);
        chk("add_we", 32'(reg_we_o), 32'd1);
        chk("add_stall_after", 32'(stallreq_o), 32'd0);
        step();
        chk("idle_valid", 32'(valid_o), 32'd0);
        mem_tx("lb1001", EXE_LB_OP, 32'h1001, 32'h0, 32'h1280_3456, 3, 4'b0010, 32'h0, 1'b0, 32'h0000_0034);
        mem_tx("lb1002", EXE_LB_OP, 32'h1002, 32'h0, 32'h1280_3456, 1, 4'b0100, 32'h0, 1'b0, 32'hFFFF_FF80);
        mem_tx("lbu1002", EXE_LBU_OP, 32'h1002, 32'h0, 32'h1280_3456, 2, 4'b0100, 32'h0, 1'b0, 32'h0000_0080);
        mem_tx("lhu2002", EXE_LHU_OP, 32'h2002, 32'h0, 32'hBEEF_1234, 1, 4'b1100, 32'h0, 1'b0, 32'h0000_BEEF);
        mem_tx("lh2002", EXE_LH_OP, 32'h2002, 32'h0, 32'hBEEF_1234, 1, 4'b1100, 32'h0, 1'b0, 32'hFFFF_BEEF);
        mem_tx("lh2000", EXE_LH_OP, 32'h2000, 32'h0, 32'hBEEF_1234, 1, 4'b0011, 32'h0, 1'b0, 32'h0000_1234);
        mem_tx("lw2008", EXE_LW_OP, 32'h2008, 32'h0, 32'hCAFE_F00D, 2, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D);
        mem_tx("sw3004", EXE_SW_OP, 32'h3004, 32'hDEAD_BEEF, 32'h0, 5, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0);
        mem_tx("sb3003", EXE_SB_OP, 32'h3003, 32'h1234_56AB, 32'h0, 1, 4'b1000, 32'hABAB_ABAB, 1'b1, 32'h0);
        mem_tx("sh3002", EXE_SH_OP, 32'h3002, 32'h1234_CAFE, 32'h0, 2, 4'b1100, 32'hCAFE_CAFE, 1'b1, 32'h0);
        mis_tx("lw4002", EXE_LW_OP, 32'h4002);
        mis_tx("sh4001", EXE_SH_OP, 32'h4001);
        issue(EXE_LW_OP, 5'd6, 32'h5000, 32'h0);
        step();
        valid_i = 1'b0;
        aluop_i = EXE_ADD_OP;
        #1;
        chk("rstbus_req_c1", 32'(bus_if.req), 32'd1);
        step();
        chk("rstbus_stall_c2", 32'(stallreq_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstbus_req_drop", 32'(bus_if.req), 32'd0);
        chk("rstbus_stall_drop", 32'(stallreq_o), 32'd0);
        chk("rstbus_addr", bus_if.addr, 32'h0);
        step();
        rst = 1'b0;
        step();
        bus_if.ack = 1'b1;
        bus_if.rdata = 32'h1111_1111;
        #1;
        chk("late_ack_stall", 32'(stallreq_o), 32'd0);
        step();
        bus_if.ack = 1'b0;
        #1;
        chk("late_ack_valid", 32'(valid_o), 32'd0);
        chk("late_ack_req", 32'(bus_if.req), 32'd0);
        issue(EXE_ADD_OP, 5'd9, 32'h77, 32'h0);
        step();
        valid_i = 1'b0;
        #1;
        chk("add2_valid", 32'(valid_o), 32'd1);
        chk("add2_waddr", 32'(reg_waddr_o), 32'd9);
        chk("add2_wdata", reg_wdata_o, 32'h77);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
        $finish;
    end
endmodule
